// File: rtl/store_buffer_pkg.sv
// Shared access-type and error-code encodings for the store buffer and its users.
package store_buffer_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_BU = 3'd4,
        MEM_HU = 3'd5
    } mem_dt_e;

    typedef enum logic [1:0] {
        ENONE    = 2'd0,
        ENOALIGN = 2'd1,
        EINVAL   = 2'd2
    } errno_e;

endpackage

// File: rtl/store_buffer.sv
// Write-back store buffer: FIFO of byte-masked stores drained to memory,
// with zero-latency per-byte store-to-load forwarding.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wd,
    input  mem_dt_e       c_dt,
    input  logic          c_we,
    input  logic          c_re,
    output logic [31:0]   c_rd,
    output logic          c_stall,
    output errno_e        err,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wd,
    output logic [3:0]    m_be,
    output logic          m_we,
    input  logic [31:0]   m_rd,
    input  logic          m_ready,
    input  logic          flush,
    output logic          empty
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned WAW = AW - 2;

    logic [DEPTH-1:0] valid_q;
    logic [WAW-1:0]   addr_q [DEPTH];
    logic [3:0]       mask_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    logic [3:0]  req_mask;
    logic [31:0] req_data;
    logic        misalign;
    logic        full;
    logic        req_ok;
    logic        drain;
    logic        enq;
    logic [31:0] merged;
    logic [31:0] shifted;
    logic [PW-1:0] idx;

    // Byte-lane mask and alignment check shared by loads and stores
    always_comb begin
        req_mask = 4'b0000;
        misalign = 1'b0;
        case (c_dt)
            MEM_B, MEM_BU: req_mask = 4'b0001 << c_addr[1:0];
            MEM_H, MEM_HU: begin
                req_mask = 4'b0011 << c_addr[1:0];
                misalign = c_addr[0];
            end
            MEM_W: begin
                req_mask = 4'b1111;
                misalign = |c_addr[1:0];
            end
            default: misalign = 1'b1;
        endcase
    end

    assign req_data = c_wd << {c_addr[1:0], 3'b000};

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign req_ok  = (c_we ^ c_re) & ~misalign;
    assign drain   = rst & ~empty & ~c_re & m_ready;
    assign c_stall = rst & req_ok & ((flush & ~empty) | (c_we & full & ~drain));
    assign enq     = rst & c_we & ~c_re & ~misalign & ~c_stall;

    always_comb begin
        err = ENONE;
        if (rst) begin
            if (c_we && c_re)
                err = EINVAL;
            else if ((c_we || c_re) && misalign)
                err = ENOALIGN;
        end
    end

    assign m_we   = drain;
    assign m_addr = drain ? {addr_q[head_q], 2'b00} : {c_addr[AW-1:2], 2'b00};
    assign m_be   = drain ? mask_q[head_q] : 4'b0000;
    assign m_wd   = drain ? data_q[head_q] : 32'h0;

    // Oldest-to-youngest scan so the youngest matching byte wins
    always_comb begin
        merged = m_rd;
        idx    = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && addr_q[idx] == c_addr[AW-1:2]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mask_q[idx][b])
                        merged[8*b +: 8] = data_q[idx][8*b +: 8];
                end
            end
        end
    end

    assign shifted = merged >> {c_addr[1:0], 3'b000};

    always_comb begin
        case (c_dt)
            MEM_B:   c_rd = {{24{shifted[7]}}, shifted[7:0]};
            MEM_BU:  c_rd = {24'h0, shifted[7:0]};
            MEM_H:   c_rd = {{16{shifted[15]}}, shifted[15:0]};
            MEM_HU:  c_rd = {16'h0, shifted[15:0]};
            default: c_rd = shifted;
        endcase
    end

    // Drain clears before enqueue sets, so a full-buffer swap keeps the slot valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                mask_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (drain) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= c_addr[AW-1:2];
                mask_q[tail_q]  <= req_mask;
                data_q[tail_q]  <= req_data;
                tail_q          <= tail_q + PW'(1);
            end
            case ({enq, drain})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer with a word-addressed memory model.
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] c_addr;
    logic [31:0] c_wd;
    mem_dt_e     c_dt;
    logic        c_we;
    logic        c_re;
    logic [31:0] c_rd;
    logic        c_stall;
    errno_e      err;
    logic [31:0] m_addr;
    logic [31:0] m_wd;
    logic [3:0]  m_be;
    logic        m_we;
    logic [31:0] m_rd;
    logic        m_ready;
    logic        flush;
    logic        empty;

    logic [31:0] mem [16384];
    logic        pl_en;
    logic [31:0] pl_addr;
    logic [31:0] pl_data;
    int          n_writes = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_before;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .c_addr(c_addr), .c_wd(c_wd), .c_dt(c_dt), .c_we(c_we), .c_re(c_re),
        .c_rd(c_rd), .c_stall(c_stall), .err(err),
        .m_addr(m_addr), .m_wd(m_wd), .m_be(m_be), .m_we(m_we),
        .m_rd(m_rd), .m_ready(m_ready), .flush(flush), .empty(empty)
    );

    always_comb m_rd = mem[m_addr[15:2]];

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr[15:2]] <= pl_data;
        if (m_we && m_ready) begin
            for (int b = 0; b < 4; b++)
                if (m_be[b]) mem[m_addr[15:2]][8*b +: 8] <= m_wd[8*b +: 8];
            n_writes <= n_writes + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic req(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] wd, input mem_dt_e dt);
        c_we = we; c_re = re; c_addr = a; c_wd = wd; c_dt = dt;
    endtask

    task automatic idle();
        req(1'b0, 1'b0, 32'h0, 32'h0, MEM_W);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; m_ready = 1'b0; flush = 1'b0; pl_en = 1'b0;
        pl_addr = 32'h0; pl_data = 32'h0;
        idle();
        repeat (2) tick();
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_mwe", 32'(m_we), 32'd0);
        check("rst_stall", 32'(c_stall), 32'd0);
        check("rst_err", 32'(err), 32'(ENONE));
        rst = 1'b1;
        tick();

        // sw then forwarded lw with memory stalled, then drain
        req(1'b1, 1'b0, 32'h1000, 32'd32, MEM_W); #1;
        check("sw_stall", 32'(c_stall), 32'd0);
        check("sw_err", 32'(err), 32'(ENONE));
        tick();
        req(1'b0, 1'b1, 32'h1000, 32'h0, MEM_W); #1;
        check("fwd_lw", c_rd, 32'd32);
        check("fwd_mwe", 32'(m_we), 32'd0);
        tick();
        idle(); m_ready = 1'b1; #1;
        check("drain_we", 32'(m_we), 32'd1);
        check("drain_addr", m_addr, 32'h1000);
        check("drain_wd", m_wd, 32'd32);
        check("drain_be", 32'(m_be), 32'hf);
        tick();
        m_ready = 1'b0; #1;
        check("drain_empty", 32'(empty), 32'd1);
        req(1'b0, 1'b1, 32'h1000, 32'h0, MEM_W); #1;
        check("mem_lw", c_rd, 32'd32);
        tick();

        // byte merge over a word store
        idle(); preload(32'h1000, 32'h0);
        req(1'b1, 1'b0, 32'h1000, 32'hdeadbeef, MEM_W); tick();
        req(1'b1, 1'b0, 32'h1001, 32'h11, MEM_B); tick();
        req(1'b0, 1'b1, 32'h1000, 32'h0, MEM_W); #1;
        check("merge_lw", c_rd, 32'hdead11ef);
        tick();
        req(1'b0, 1'b1, 32'h1001, 32'h0, MEM_B); #1;
        check("merge_lb1", c_rd, 32'h00000011);
        tick();
        req(1'b0, 1'b1, 32'h1003, 32'h0, MEM_B); #1;
        check("merge_lb3", c_rd, 32'hffffffde);
        tick();
        idle(); m_ready = 1'b1; #1;
        check("mrg_d0_be", 32'(m_be), 32'hf);
        check("mrg_d0_wd", m_wd, 32'hdeadbeef);
        tick(); #1;
        check("mrg_d1_be", 32'(m_be), 32'h2);
        check("mrg_d1_wd", m_wd, 32'h00001100);
        tick(); m_ready = 1'b0;

        // half store merged with memory, signed and unsigned extraction
        preload(32'h1000, 32'h00001234);
        req(1'b1, 1'b0, 32'h1002, 32'h8000, MEM_H); tick();
        req(1'b0, 1'b1, 32'h1000, 32'h0, MEM_H); #1;
        check("lh_lo", c_rd, 32'h00001234);
        tick();
        req(1'b0, 1'b1, 32'h1002, 32'h0, MEM_H); #1;
        check("lh_hi", c_rd, 32'hffff8000);
        tick();
        req(1'b0, 1'b1, 32'h1002, 32'h0, MEM_HU); #1;
        check("lhu_hi", c_rd, 32'h00008000);
        tick();
        idle(); m_ready = 1'b1; #1;
        check("sh_be", 32'(m_be), 32'hc);
        check("sh_wd", m_wd, 32'h80000000);
        tick(); m_ready = 1'b0;

        // full buffer: stall, then enqueue and drain in the same cycle
        for (int i = 0; i < 4; i++) begin
            req(1'b1, 1'b0, 32'h2000 + 32'(4*i), 32'(i+1), MEM_W); #1;
            check("fill_stall", 32'(c_stall), 32'd0);
            tick();
        end
        req(1'b1, 1'b0, 32'h2010, 32'd5, MEM_W); #1;
        check("full_stall", 32'(c_stall), 32'd1);
        tick(); #1;
        check("full_hold", 32'(c_stall), 32'd1);
        m_ready = 1'b1; #1;
        check("swap_stall", 32'(c_stall), 32'd0);
        check("swap_we", 32'(m_we), 32'd1);
        check("swap_addr", m_addr, 32'h2000);
        tick();
        m_ready = 1'b0;
        req(1'b1, 1'b0, 32'h2100, 32'd6, MEM_W); #1;
        check("still_full", 32'(c_stall), 32'd1);
        idle(); m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fifo_addr", m_addr, 32'h2004 + 32'(4*i));
            check("fifo_wd", m_wd, 32'(i+2));
            tick();
        end
        m_ready = 1'b0; #1;
        check("fifo_empty", 32'(empty), 32'd1);

        // misaligned and illegal requests
        req(1'b1, 1'b0, 32'h1001, 32'h5, MEM_W); #1;
        check("mis_sw_err", 32'(err), 32'(ENOALIGN));
        check("mis_sw_stall", 32'(c_stall), 32'd0);
        tick();
        req(1'b0, 1'b1, 32'h1003, 32'h0, MEM_H); #1;
        check("mis_lh_err", 32'(err), 32'(ENOALIGN));
        tick();
        req(1'b1, 1'b1, 32'h1000, 32'h7, MEM_W); #1;
        check("inval_err", 32'(err), 32'(EINVAL));
        tick();
        idle(); #1;
        check("bad_noenq", 32'(empty), 32'd1);
        check("idle_err", 32'(err), 32'(ENONE));

        // reset discards pending stores without writing
        for (int i = 0; i < 3; i++) begin
            req(1'b1, 1'b0, 32'h4000 + 32'(4*i), 32'h40 + 32'(i), MEM_W); tick();
        end
        idle(); #1;
        check("pre_rst_full", 32'(empty), 32'd0);
        wr_before = n_writes;
        m_ready = 1'b1; rst = 1'b0; #1;
        check("mid_rst_we", 32'(m_we), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_stall", 32'(c_stall), 32'd0);
        tick();
        rst = 1'b1; #1;
        check("post_rst_we", 32'(m_we), 32'd0);
        tick();
        check("rst_no_write", 32'(n_writes), 32'(wr_before));
        m_ready = 1'b0;

        // flush drains in FIFO order while stalling the CPU
        for (int i = 0; i < 3; i++) begin
            req(1'b1, 1'b0, 32'h3000 + 32'(4*i), 32'ha + 32'(i), MEM_W); tick();
        end
        req(1'b1, 1'b0, 32'h300c, 32'hd, MEM_W);
        flush = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("fl_stall", 32'(c_stall), 32'd1);
            check("fl_we", 32'(m_we), 32'd1);
            check("fl_addr", m_addr, 32'h3000 + 32'(4*i));
            check("fl_wd", m_wd, 32'ha + 32'(i));
            tick();
        end
        #1;
        check("fl_empty", 32'(empty), 32'd1);
        check("fl_unstall", 32'(c_stall), 32'd0);
        check("fl_nowe", 32'(m_we), 32'd0);
        tick();
        flush = 1'b0; idle(); #1;
        check("fl_tail_addr", m_addr, 32'h300c);
        check("fl_tail_wd", m_wd, 32'hd);
        tick();
        m_ready = 1'b0; #1;
        check("final_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of store entries (power of 2, 2..16).
REQ-002 SHALL have parameter AW, default 32, byte-address width.
REQ-003 SHALL have ports: clk  in  1  clock (all state on rising edge).
REQ-004 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: c_addr in AW CPU byte address; c_wd in 32 CPU store data (LSB-justified); c_dt in mem_dt_e access type; c_we in 1 store request; c_re in 1 load request.
REQ-006 SHALL have ports: c_rd out 32 load data (sign/zero-extended per c_dt); c_stall out 1 CPU must hold request; err out errno_e.
REQ-007 SHALL have ports: m_addr out AW word-aligned address; m_wd out 32; m_be out 4 byte enables; m_we out 1; m_rd in 32 memory word read (combinational on m_addr); m_ready in 1 memory accepts write this cycle.
REQ-008 SHALL have ports: flush in 1 drain request; empty out 1 no valid entries.

Function
REQ-009 Each entry SHALL hold valid, word address (c_addr[AW-1:2]), 4-bit byte mask, 32-bit byte-lane-aligned data.
REQ-010 Byte/half/word store SHALL produce mask 0001<<a[1:0], 0011<<a[1:0], 1111; data shifted to lanes.
REQ-011 Misaligned half (a[0]=1) or word (a[1:0]!=0) SHALL set err=ENOALIGN for that cycle, not enqueue, not read memory, not stall; otherwise err=ENONE.
REQ-012 Store with c_we=1, not full, SHALL enqueue at tail on the next rising edge; c_stall=0.
REQ-013 Store with buffer full SHALL assert c_stall combinationally unless the head drains in the same cycle, in which case enqueue and drain SHALL both occur (count unchanged).
REQ-014 Drain: when count>0, c_re=0 and m_ready=1, SHALL drive m_we=1, m_addr={head word,2'b00}, m_be/m_wd from head, and pop head at edge; entries drain strictly FIFO.
REQ-015 Loads SHALL take priority over draining; m_we=0 in any cycle with c_re=1.
REQ-016 Load: needed-byte mask derived as REQ-010; c_rd combinational in the same cycle (zero latency).
REQ-017 Load SHALL merge per byte: for each needed byte, the youngest valid entry with matching word address and mask bit supplies it; remaining bytes from m_rd with m_addr = load word address.
REQ-018 Merge includes an entry enqueued in the same cycle? No: only entries valid before the edge are searched; c_we and c_re SHALL never both be 1 (err=EINVAL, no action).
REQ-019 Load result SHALL be extracted by a[1:0] and extended: byte/half sign-extend, ubyte/uhalf zero-extend, word unchanged.
REQ-020 c_stall SHALL never be asserted for a load; forwarding is always complete by REQ-017.
REQ-021 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH; empty = (count==0).
REQ-022 flush=1 SHALL stall every CPU request (c_stall=1) and drain per REQ-014 until empty, then c_stall follows normal rules.
REQ-023 When idle and empty: m_we=0, m_be=0, m_addr=c_addr word-aligned.

Reset
REQ-024 rst=0 SHALL immediately clear all valid bits, head, tail, count; outputs m_we=0, c_stall=0, empty=1, err=ENONE.
REQ-025 Reset mid-operation SHALL discard undrained stores without any memory write; no partial write SHALL be issued in a cycle where rst=0.

Verification
REQ-026 sw 32 @0x1000, then lw @0x1000 next cycle, m_ready=0 -> c_rd=32, m_we=0; later drain writes 0x1000=32.
REQ-027 sw 0xdeadbeef @0x1000, sb 0x11 @0x1001, lw @0x1000, memory holds 0 -> c_rd=0xdead11ef; lb @0x1001 -> 0x00000011; lb @0x1003 -> 0xffffffde.
REQ-028 DEPTH=4, m_ready=0, five stores -> fifth stalls; m_ready=1 with fifth held -> enqueue+drain same cycle, count stays 4.
REQ-029 sh @0x1002 0x8000, memory word 0x00001234, lh @0x1000 -> 0x00001234, lh @0x1002 -> 0xffff8000, lhu @0x1002 -> 0x00008000.
REQ-030 sw @0x1001 -> err=ENOALIGN, count unchanged; three stores then rst=0 for one cycle -> empty=1, no m_we observed.
REQ-031 Three stores, flush=1, m_ready=1 -> m_we on 3 consecutive cycles in FIFO order, then empty=1 and c_stall drops.
